dac_stream_buffer: RTL and testbench

Elastic output stage between the `top_level` DAC batch producer and the DAC AXI-stream slave. It absorbs batches from `top_level` through a valid/ready handshake and holds them in a DEPTH-entry FIFO. It presents a registered, always-valid stream to the DAC, inserting zero batches while priming or underflowed. It also reports fill level and a saturating underflow-event count for the PS status registers.

---
 rtl/dac_stream_buffer.sv | 135 +++++++++++++
 tb/tb_dac_stream_buffer.sv | 378 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dac_stream_buffer.sv
// dac_stream_buffer: elastic batch FIFO in front of the DAC AXI-stream.
// Primes to PRIME_LEVEL, then streams; pads with zero batches when dry.
module dac_stream_buffer #(
  parameter int DATA_W      = 1024,
  parameter int DEPTH       = 8,
  parameter int PRIME_LEVEL = 4,
  parameter int UF_W        = 32
) (
  input  logic                   clk,
  input  logic                   sys_rst,
  input  logic [DATA_W-1:0]      batch_in,
  input  logic                   batch_valid_in,
  output logic                   batch_rdy_out,
  input  logic                   flush,
  output logic [DATA_W-1:0]      dac_tdata,
  output logic                   dac_tvalid,
  input  logic                   dac_tready,
  output logic [$clog2(DEPTH):0] fill_level,
  output logic                   streaming,
  output logic [UF_W-1:0]        underflow_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int FW = PW + 1;

  localparam logic [FW-1:0] FULL  = FW'(DEPTH);
  localparam logic [FW-1:0] PRIME = FW'(PRIME_LEVEL);
  localparam logic [UF_W-1:0] UF_MAX = '1;

  typedef enum logic {
    S_PRIME,
    S_RUN
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;

  logic empty;
  logic xfer;
  logic wr_en;
  logic pop;
  logic uf_evt;
  logic load_zero;

  assign empty = (fill_level == '0);
  assign xfer  = dac_tvalid & dac_tready;

  // Full refuses writes even when a pop lands in the same cycle.
  assign batch_rdy_out = dac_tvalid
                       & (fill_level != FULL)
                       & ~flush;

  assign wr_en = batch_valid_in & batch_rdy_out;

  assign streaming = (state_q == S_RUN);

  always_comb begin
    state_d   = state_q;
    pop       = 1'b0;
    uf_evt    = 1'b0;
    load_zero = 1'b0;
    unique case (state_q)
      S_PRIME: begin
        load_zero = xfer;
        if (fill_level >= PRIME) begin
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        if (xfer) begin
          if (empty) begin
            load_zero = 1'b1;
            uf_evt    = 1'b1;
            state_d   = S_PRIME;
          end else begin
            pop = 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= batch_in;
    end
  end

  always_ff @(posedge clk) begin
    if (sys_rst) begin
      state_q         <= S_PRIME;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fill_level      <= '0;
      dac_tdata       <= '0;
      dac_tvalid      <= 1'b0;
      underflow_count <= '0;
    end else begin
      dac_tvalid <= 1'b1;
      if (flush) begin
        state_q    <= S_PRIME;
        wr_ptr     <= '0;
        rd_ptr     <= '0;
        fill_level <= '0;
        dac_tdata  <= '0;
      end else begin
        state_q <= state_d;
        if (wr_en) begin
          wr_ptr <= wr_ptr + 1'b1;
        end
        if (pop) begin
          rd_ptr <= rd_ptr + 1'b1;
        end
        if (wr_en && !pop) begin
          fill_level <= fill_level + 1'b1;
        end else if (pop && !wr_en) begin
          fill_level <= fill_level - 1'b1;
        end
        unique case (1'b1)
          load_zero: dac_tdata <= '0;
          pop:       dac_tdata <= mem[rd_ptr];
          default:   ;
        endcase
        if (uf_evt && underflow_count != UF_MAX) begin
          underflow_count <= underflow_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dac_stream_buffer.sv
// Bench for dac_stream_buffer: queue reference model checked every cycle,
// plus directed scenarios with hand-derived cycle expectations.
`timescale 1ns/1ps
module tb_dac_stream_buffer;

  localparam int DW    = 1024;
  localparam int DEPTH = 8;
  localparam int PL    = 4;
  localparam int UW    = 32;
  localparam int FW    = 4;
  localparam int SDW   = 64;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          sys_rst = 1'b1;
  logic [DW-1:0] batch_in = '0;
  logic          batch_valid_in = 1'b0;
  logic          flush = 1'b0;
  logic          dac_tready = 1'b0;
  logic          batch_rdy_out;
  logic [DW-1:0] dac_tdata;
  logic          dac_tvalid;
  logic [FW-1:0] fill_level;
  logic          streaming;
  logic [UW-1:0] underflow_count;

  logic [SDW-1:0] s_batch = '0;
  logic           s_valid = 1'b0;
  logic           s_rdy;
  logic           s_flush = 1'b0;
  logic [SDW-1:0] s_tdata;
  logic           s_tvalid;
  logic           s_tready = 1'b1;
  logic [2:0]     s_fill;
  logic           s_stream;
  logic [1:0]     s_uf;

  dac_stream_buffer #(
    .DATA_W(DW), .DEPTH(DEPTH),
    .PRIME_LEVEL(PL), .UF_W(UW)
  ) dut (
    .clk(clk), .sys_rst(sys_rst),
    .batch_in(batch_in),
    .batch_valid_in(batch_valid_in),
    .batch_rdy_out(batch_rdy_out),
    .flush(flush),
    .dac_tdata(dac_tdata),
    .dac_tvalid(dac_tvalid),
    .dac_tready(dac_tready),
    .fill_level(fill_level),
    .streaming(streaming),
    .underflow_count(underflow_count)
  );

  dac_stream_buffer #(
    .DATA_W(SDW), .DEPTH(4),
    .PRIME_LEVEL(1), .UF_W(2)
  ) dut_sat (
    .clk(clk), .sys_rst(sys_rst),
    .batch_in(s_batch),
    .batch_valid_in(s_valid),
    .batch_rdy_out(s_rdy),
    .flush(s_flush),
    .dac_tdata(s_tdata),
    .dac_tvalid(s_tvalid),
    .dac_tready(s_tready),
    .fill_level(s_fill),
    .streaming(s_stream),
    .underflow_count(s_uf)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name,
                     input logic [DW-1:0] act,
                     input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h (low 64b) t=%0t",
               name, act[63:0], exp[63:0], $time);
    end
  endtask

  task automatic chkv(input string name,
                      input logic [63:0] act,
                      input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h t=%0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int id);
    logic [63:0] w;
    w = 64'hDA7A_0000_0000_0000 + 64'(id);
    return {16{w}};
  endfunction

  // Reference model: a queue of batches, a run flag and the output word.
  logic [DW-1:0] mq[$];
  logic          m_run = 1'b0;
  logic          m_valid = 1'b0;
  logic [DW-1:0] m_data = '0;
  logic [UW-1:0] m_uf = '0;
  logic          m_run0;
  logic          m_acc;
  logic          m_xf;
  int            m_pre;
  bit            armed = 1'b0;

  always @(posedge clk) begin
    m_pre = mq.size();
    if (sys_rst) begin
      mq.delete();
      m_run   = 1'b0;
      m_valid = 1'b0;
      m_data  = '0;
      m_uf    = '0;
      armed   = 1'b1;
    end else if (flush) begin
      mq.delete();
      m_run   = 1'b0;
      m_data  = '0;
      m_valid = 1'b1;
    end else begin
      m_run0 = m_run;
      m_acc  = m_valid && (m_pre < DEPTH) && batch_valid_in;
      m_xf   = m_valid && dac_tready;
      if (m_xf) begin
        if (m_run0 && m_pre > 0) begin
          m_data = mq.pop_front();
        end else begin
          m_data = '0;
          if (m_run0) begin
            m_run = 1'b0;
            if (m_uf != '1) m_uf = m_uf + 1'b1;
          end
        end
      end
      if (!m_run0 && m_pre >= PL) m_run = 1'b1;
      if (m_acc) mq.push_back(batch_in);
      m_valid = 1'b1;
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      chk("m_tdata", dac_tdata, m_data);
      chkv("m_tvalid", 64'(dac_tvalid), 64'(m_valid));
      chkv("m_fill", 64'(fill_level), 64'(mq.size()));
      chkv("m_stream", 64'(streaming), 64'(m_run));
      chkv("m_uf", 64'(underflow_count), 64'(m_uf));
      chkv("m_rdy", 64'(batch_rdy_out),
           64'(m_valid && mq.size() != DEPTH && !flush));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic rdy);
    sys_rst = 1'b1;
    batch_valid_in = 1'b0;
    flush = 1'b0;
    dac_tready = rdy;
    s_valid = 1'b0;
    step();
    step();
    sys_rst = 1'b0;
    @(negedge clk);
    chk("rst_tdata", dac_tdata, '0);
    chkv("rst_tvalid", 64'(dac_tvalid), 64'(0));
    chkv("rst_fill", 64'(fill_level), 64'(0));
    chkv("rst_stream", 64'(streaming), 64'(0));
    chkv("rst_uf", 64'(underflow_count), 64'(0));
    chkv("rst_rdy", 64'(batch_rdy_out), 64'(0));
    step();
  endtask

  initial begin
    logic [DW-1:0] exp_d;
    logic [DW-1:0] ghost;
    int idx;
    int pv;
    int pr;
    int ef;

    // Prime and drain
    do_reset(1'b1);
    for (int c = 0; c <= 10; c++) begin
      batch_valid_in = (c < 4);
      batch_in = mk(160 + c);
      @(negedge clk);
      exp_d = (c >= 6 && c <= 9) ? mk(160 + c - 6) : '0;
      ef = (c <= 4) ? c : (c == 5) ? 4 : (c >= 9) ? 0 : 9 - c;
      chk("pd_tdata", dac_tdata, exp_d);
      chkv("pd_stream", 64'(streaming),
           64'(c >= 5 && c <= 9));
      chkv("pd_uf", 64'(underflow_count), 64'(c == 10));
      chkv("pd_fill", 64'(fill_level), 64'(ef));
      step();
    end

    // Backpressure while A1 is presented
    do_reset(1'b1);
    for (int c = 0; c <= 11; c++) begin
      batch_valid_in = (c < 4);
      batch_in = mk(160 + c);
      dac_tready = !(c >= 7 && c <= 9);
      @(negedge clk);
      if (c >= 7 && c <= 10) begin
        chk("bp_hold", dac_tdata, mk(161));
        chkv("bp_fill", 64'(fill_level), 64'(2));
      end
      if (c == 11) chk("bp_next", dac_tdata, mk(162));
      chkv("bp_uf", 64'(underflow_count), 64'(0));
      step();
    end

    // Full with B8 held off
    do_reset(1'b0);
    idx = 0;
    for (int c = 0; c < 12; c++) begin
      batch_valid_in = 1'b1;
      batch_in = mk(176 + idx);
      @(negedge clk);
      if (batch_rdy_out) idx++;
      step();
    end
    chkv("full_acc", 64'(idx), 64'(8));
    batch_in = mk(176 + 8);
    @(negedge clk);
    chkv("full_fill", 64'(fill_level), 64'(8));
    chkv("full_rdy", 64'(batch_rdy_out), 64'(0));
    step();
    dac_tready = 1'b1;
    for (int k = 0; k <= 10; k++) begin
      @(negedge clk);
      if (k == 0) chkv("full_rdy_lo", 64'(batch_rdy_out), 64'(0));
      if (k == 1) chkv("full_rdy_hi", 64'(batch_rdy_out), 64'(1));
      if (k >= 1 && k <= 9) chk("full_order", dac_tdata, mk(176 + k - 1));
      step();
      if (k == 1) batch_valid_in = 1'b0;
    end

    // Flush in RUN with fill 5 and two underflows recorded
    do_reset(1'b1);
    for (int r = 0; r < 2; r++) begin
      for (int c = 0; c <= 10; c++) begin
        batch_valid_in = (c < 4);
        batch_in = mk(192 + c);
        step();
      end
    end
    dac_tready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      batch_valid_in = 1'b1;
      batch_in = mk(200 + c);
      step();
    end
    ghost = mk(16'hDEAD);
    flush = 1'b1;
    batch_in = ghost;
    @(negedge clk);
    chkv("fl_pre_fill", 64'(fill_level), 64'(5));
    chkv("fl_pre_run", 64'(streaming), 64'(1));
    chkv("fl_pre_uf", 64'(underflow_count), 64'(2));
    step();
    flush = 1'b0;
    batch_valid_in = 1'b0;
    @(negedge clk);
    chkv("fl_fill", 64'(fill_level), 64'(0));
    chk("fl_tdata", dac_tdata, '0);
    chkv("fl_stream", 64'(streaming), 64'(0));
    chkv("fl_uf", 64'(underflow_count), 64'(2));
    step();
    dac_tready = 1'b1;
    for (int c = 0; c <= 10; c++) begin
      batch_valid_in = (c < 4);
      batch_in = mk(208 + c);
      @(negedge clk);
      if (c == 6) chk("fl_first", dac_tdata, mk(208));
      chkv("fl_ghost", 64'(dac_tdata == ghost), 64'(0));
      step();
    end

    // Mid-stream reset with fill 3
    do_reset(1'b0);
    for (int c = 0; c < 4; c++) begin
      batch_valid_in = 1'b1;
      batch_in = mk(224 + c);
      step();
    end
    batch_valid_in = 1'b0;
    step();
    dac_tready = 1'b1;
    step();
    dac_tready = 1'b0;
    @(negedge clk);
    chkv("mr_fill", 64'(fill_level), 64'(3));
    chkv("mr_run", 64'(streaming), 64'(1));
    step();
    sys_rst = 1'b1;
    step();
    sys_rst = 1'b0;
    @(negedge clk);
    chkv("mr_tvalid0", 64'(dac_tvalid), 64'(0));
    chkv("mr_fill0", 64'(fill_level), 64'(0));
    chk("mr_tdata0", dac_tdata, '0);
    chkv("mr_stream0", 64'(streaming), 64'(0));
    chkv("mr_uf0", 64'(underflow_count), 64'(0));
    step();
    @(negedge clk);
    chkv("mr_tvalid1", 64'(dac_tvalid), 64'(1));
    chkv("mr_rdy1", 64'(batch_rdy_out), 64'(1));
    step();

    // Saturation on the narrow-counter instance
    do_reset(1'b0);
    for (int k = 1; k <= 5; k++) begin
      s_valid = 1'b1;
      s_batch = 64'h5A00 + 64'(k);
      @(negedge clk);
      chkv("sat_rdy", 64'(s_rdy), 64'(1));
      step();
      s_valid = 1'b0;
      @(negedge clk);
      chkv("sat_fill", 64'(s_fill), 64'(1));
      step();
      @(negedge clk);
      chkv("sat_run", 64'(s_stream), 64'(1));
      step();
      @(negedge clk);
      chkv("sat_data", s_tdata, 64'h5A00 + 64'(k));
      step();
      @(negedge clk);
      chkv("sat_stop", 64'(s_stream), 64'(0));
      chkv("sat_uf", 64'(s_uf), 64'((k < 3) ? k : 3));
      step();
    end

    // Randomized traffic against the model
    do_reset(1'b1);
    pv = 60;
    pr = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 200 == 0) begin
        pv = $urandom_range(20, 95);
        pr = $urandom_range(20, 95);
      end
      batch_valid_in = ($urandom_range(0, 99) < pv);
      dac_tready = ($urandom_range(0, 99) < pr);
      flush = ($urandom_range(0, 99) < 2);
      sys_rst = ($urandom_range(0, 299) == 0);
      for (int w = 0; w < DW / 32; w++) begin
        batch_in[w*32 +: 32] = $urandom;
      end
      step();
    end
    sys_rst = 1'b0;
    flush = 1'b0;
    batch_valid_in = 1'b0;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
